// File: rtl/sgmii_link_seq_pkg.sv
// Shared definitions for the SGMII link bring-up sequencer: state encoding,
// cycle-counter width and the per-state reset/PHY output decode.
package sgmii_link_seq_pkg;

  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_PMA_RST   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_WAIT_LINK = 3'd5,
    ST_UP        = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  typedef struct packed {
    logic pma;
    logic pcs;
    logic mmcm;
    logic phy_rstn;
  } rst_out_t;

  // Reset pattern driven towards the PCS/PMA core, MMCM and external PHY.
  function automatic rst_out_t decode_resets(state_t s);
    rst_out_t r;
    case (s)
      ST_PMA_RST:   r = '{pma: 1'b1, pcs: 1'b1, mmcm: 1'b1, phy_rstn: 1'b1};
      ST_WAIT_DONE: r = '{pma: 1'b0, pcs: 1'b1, mmcm: 1'b1, phy_rstn: 1'b1};
      ST_WAIT_LOCK: r = '{pma: 1'b0, pcs: 1'b1, mmcm: 1'b0, phy_rstn: 1'b1};
      ST_WAIT_LINK,
      ST_UP:        r = '{pma: 1'b0, pcs: 1'b0, mmcm: 1'b0, phy_rstn: 1'b1};
      default:      r = '{pma: 1'b1, pcs: 1'b1, mmcm: 1'b1, phy_rstn: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sgmii_link_seq_sync.sv
// sync2: two-flop synchronizer for one asynchronous level, cleared
// asynchronously to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same
      // edge; blocking here would collapse the chain into a single flop.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sgmii_link_seq.sv
// sgmii_link_seq: bring-up sequencer for an SGMII PCS/PMA core, its user-clock
// MMCM and the external PHY. Walks PHY reset, PMA reset and three wait
// phases with timeout and bounded retry, then monitors the link while UP.
// Build option: define SGMII_LINK_SEQ_HOLDOFF_EN to debounce link_status
// loss in UP over HOLDOFF_CYC consecutive low cycles.
module sgmii_link_seq
  import sgmii_link_seq_pkg::*;
#(
  parameter int unsigned PHY_RST_CYC = 1250,
  parameter int unsigned PMA_RST_CYC = 16,
  parameter int unsigned TIMEOUT_CYC = 1048576,
  parameter int unsigned MAX_RETRY   = 7,
  parameter int unsigned HOLDOFF_CYC = 1024
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic       resetdone,
  input  logic       mmcm_locked,
  input  logic       link_status,
  output logic       pma_reset,
  output logic       pcs_reset,
  output logic       mmcm_reset,
  output logic       phy_rstn,
  output logic       link_up,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] retry_cnt
);

`ifdef SGMII_LINK_SEQ_HOLDOFF_EN
  localparam bit HOLDOFF_EN = 1'b1;
`else
  localparam bit HOLDOFF_EN = 1'b0;
`endif

  // Number of consecutive synchronized low link cycles that end an UP period.
  localparam int unsigned DROP_CYC = HOLDOFF_EN ? HOLDOFF_CYC : 1;

  localparam logic [CNT_W-1:0] PHY_LAST  = CNT_W'(PHY_RST_CYC - 1);
  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(DROP_CYC - 1);
  localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRY);

  logic             done_s, locked_s, link_s, rst_ok;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_d;
  logic             attempt_fail;
  rst_out_t         rst_d;

  sync2 u_sync_done (.clk(aclk), .rst_n(aresetn), .d(resetdone),   .q(done_s));
  sync2 u_sync_lock (.clk(aclk), .rst_n(aresetn), .d(mmcm_locked), .q(locked_s));
  sync2 u_sync_link (.clk(aclk), .rst_n(aresetn), .d(link_status), .q(link_s));
  // Releases the FSM from IDLE only two edges after aresetn deasserts.
  sync2 u_sync_rst  (.clk(aclk), .rst_n(aresetn), .d(1'b1),        .q(rst_ok));

  // Next state, attempt-failure detection, counter and retry updates.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    attempt_fail = 1'b0;
    case (state_q)
      ST_IDLE:      if (rst_ok) state_d = ST_PHY_RST;
      ST_PHY_RST:   if (cnt_q == PHY_LAST) state_d = ST_PMA_RST;
      ST_PMA_RST:   if (cnt_q == PMA_LAST) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (done_s) state_d = ST_WAIT_LOCK;
                    else if (cnt_q == TO_LAST) attempt_fail = 1'b1;
      ST_WAIT_LOCK: if (locked_s) state_d = ST_WAIT_LINK;
                    else if (cnt_q == TO_LAST) attempt_fail = 1'b1;
      ST_WAIT_LINK: if (link_s) state_d = ST_UP;
                    else if (cnt_q == TO_LAST) attempt_fail = 1'b1;
      ST_UP:        if (!done_s || !locked_s || (!link_s && cnt_q == DROP_LAST))
                      attempt_fail = 1'b1;
      ST_FAIL:      state_d = ST_FAIL;
      default:      state_d = ST_IDLE;
    endcase
    if (attempt_fail) state_d = (retry_cnt == RETRY_MAX) ? ST_FAIL : ST_PMA_RST;
    // enable low overrides every other transition, including leaving FAIL.
    if (!enable) state_d = ST_IDLE;

    // One counter serves as phase timer, wait timeout and, in UP, the run
    // length of consecutive link-low cycles.
    if (state_d != state_q)  cnt_d = '0;
    else if (state_q == ST_UP) cnt_d = link_s ? '0 : cnt_q + CNT_W'(1);
    else if (state_q inside {ST_PHY_RST, ST_PMA_RST, ST_WAIT_DONE,
                             ST_WAIT_LOCK, ST_WAIT_LINK})
      cnt_d = cnt_q + CNT_W'(1);
    else cnt_d = '0;

    retry_d = retry_cnt;
    if (state_d == ST_IDLE || (state_d == ST_UP && state_q != ST_UP))
      retry_d = '0;
    else if (attempt_fail && state_d == ST_PMA_RST && retry_cnt != 8'hFF)
      retry_d = retry_cnt + 8'd1;
  end

  assign rst_d = decode_resets(state_d);

  // State, counters and outputs; outputs decode the next state so they
  // change on the same edge as the state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_cnt  <= '0;
      pma_reset  <= 1'b1;
      pcs_reset  <= 1'b1;
      mmcm_reset <= 1'b1;
      phy_rstn   <= 1'b0;
      link_up    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_cnt  <= retry_d;
      pma_reset  <= rst_d.pma;
      pcs_reset  <= rst_d.pcs;
      mmcm_reset <= rst_d.mmcm;
      phy_rstn   <= rst_d.phy_rstn;
      link_up    <= (state_d == ST_UP);
      fail       <= (state_d == ST_FAIL);
    end
  end

  assign state = state_q;

endmodule
